// File: rtl/wb_decoder.sv
// Wishbone classic single-master to multi-slave decoder with locked per-cycle routing.
// Optional stall timeout is enabled by defining WB_DECODER_TIMEOUT_EN.
module wb_decoder #(
    parameter int SLAVE_COUNT    = 2,
    parameter int SEL_WIDTH      = $clog2(SLAVE_COUNT),
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wb_cyc_i,
    input  logic                              wb_stb_i,
    input  logic [ADDR_WIDTH-1:0]             wb_adr_i,
    output logic                              wb_ack_o,
    output logic                              wb_err_o,
    output logic [DATA_WIDTH-1:0]             wb_dat_o,
    output logic [SLAVE_COUNT-1:0]            s_cyc_o,
    output logic [SLAVE_COUNT-1:0]            s_stb_o,
    input  logic [SLAVE_COUNT-1:0]            s_ack_i,
    input  logic [SLAVE_COUNT-1:0]            s_err_i,
    input  logic [SLAVE_COUNT*DATA_WIDTH-1:0] s_dat_i
);

    typedef enum logic [1:0] {IDLE, ROUTE, ERROR} state_e;

    localparam logic [SEL_WIDTH:0] SLAVE_COUNT_W = (SEL_WIDTH+1)'(SLAVE_COUNT);

    state_e               state_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [SEL_WIDTH-1:0] idx;
    logic                 mapped;
    logic                 sel_ack;
    logic                 sel_err;
    logic                 tmo_expire;

    assign idx    = wb_adr_i[ADDR_WIDTH-1 -: SEL_WIDTH];
    assign mapped = ({1'b0, idx} < SLAVE_COUNT_W);

    // Only the index bits are decoded; the slaves see the full address elsewhere.
    logic unused_adr;
    assign unused_adr = ^wb_adr_i[ADDR_WIDTH-SEL_WIDTH-1:0];

    always_comb begin
        s_cyc_o  = '0;
        s_stb_o  = '0;
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        wb_dat_o = '0;
        sel_ack  = 1'b0;
        sel_err  = 1'b0;
        for (int k = 0; k < SLAVE_COUNT; k++) begin
            if (sel_q == SEL_WIDTH'(k)) begin
                sel_ack = s_ack_i[k];
                sel_err = s_err_i[k];
            end
        end
        case (state_q)
            ROUTE: begin
                // s_cyc_o follows wb_cyc_i directly so a dropped cycle releases the slave at once.
                for (int k = 0; k < SLAVE_COUNT; k++) begin
                    if (sel_q == SEL_WIDTH'(k)) begin
                        s_cyc_o[k] = wb_cyc_i;
                        s_stb_o[k] = wb_stb_i;
                        wb_dat_o   = s_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                wb_ack_o = sel_ack;
                wb_err_o = sel_err;
            end
            ERROR:   wb_err_o = wb_cyc_i & wb_stb_i;
            default: ;
        endcase
    end

`ifdef WB_DECODER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);

    logic [CNT_W-1:0] tmo_q;
    logic             stall;

    assign stall      = wb_stb_i & ~sel_ack & ~sel_err;
    assign tmo_expire = (state_q == ROUTE) && stall && (tmo_q == CNT_W'(TIMEOUT_CYCLES-1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
`ifdef WB_DECODER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        if (mapped) begin
                            sel_q   <= idx;
                            state_q <= ROUTE;
                        end else begin
                            state_q <= ERROR;
                        end
                    end
                end
                ROUTE: begin
                    if (!wb_cyc_i)       state_q <= IDLE;
                    else if (tmo_expire) state_q <= ERROR;
                end
                ERROR: begin
                    if (!wb_cyc_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef WB_DECODER_TIMEOUT_EN
            // Count consecutive stalled strobe cycles; any response, idle strobe or exit restarts it.
            if (state_q == ROUTE && wb_cyc_i && stall && !tmo_expire)
                tmo_q <= tmo_q + 1'b1;
            else
                tmo_q <= '0;
`endif
        end
    end

endmodule
